// File: rtl/fp_sqrt_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fp_sqrt unit among N_REQ requesters.
// One operation is in flight at a time: accept -> issue -> wait (with abort timer) -> respond.
module fp_sqrt_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_exc,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    sqrt_start,
  output logic [DATA_W-1:0]       sqrt_op,
  input  logic                    sqrt_done,
  input  logic [DATA_W-1:0]       sqrt_res,
  input  logic                    sqrt_exc,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e             state;
  logic [IDX_W-1:0]   grant;
  logic [N_REQ-1:0]   grant_oh;
  logic [IDX_W-1:0]   last_grant;
  logic [TMR_W-1:0]   timer;

  // Round-robin pick results
  int unsigned        cand;
  logic [IDX_W-1:0]   cand_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  pick_op;
  logic               rsp_hs;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    cand     = 0;
    cand_idx = '0;
    pick_oh  = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(last_grant) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_any && req_valid[cand_idx]) begin
        pick_any          = 1'b1;
        pick_idx          = cand_idx;
        pick_oh[cand_idx] = 1'b1;
      end
    end
  end

  // Operand of the current winner.
  always_comb begin
    pick_op = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (pick_oh[i]) begin
        pick_op = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Grant is only offered while idle and out of reset, so a dropped valid is never taken.
  always_comb begin
    req_ready = '0;
    if (state == StIdle && !rst) begin
      req_ready = pick_oh;
    end
  end

  // Only the granted requester's rsp_ready can complete the response.
  always_comb begin
    rsp_hs = |(rsp_ready & grant_oh);
  end

  assign busy = (state != StIdle);

  // Control FSM with registered outputs; sqrt_done only matters in StWait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      grant       <= '0;
      grant_oh    <= '0;
      last_grant  <= IDX_LAST;
      timer       <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_exc     <= 1'b0;
      sqrt_start  <= 1'b0;
      sqrt_op     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_any) begin
            grant      <= pick_idx;
            grant_oh   <= pick_oh;
            sqrt_op    <= pick_op;
            sqrt_start <= 1'b1;
            state      <= StIssue;
          end
        end
        StIssue: begin
          sqrt_start <= 1'b0;
          timer      <= '0;
          state      <= StWait;
        end
        StWait: begin
          if (sqrt_done) begin
            // A result on the final timer cycle still wins over the abort.
            rsp_data  <= sqrt_res;
            rsp_exc   <= sqrt_exc;
            rsp_valid <= grant_oh;
            state     <= StResp;
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            rsp_data    <= '0;
            rsp_exc     <= 1'b1;
            rsp_valid   <= grant_oh;
            state       <= StResp;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        StResp: begin
          if (rsp_hs) begin
            rsp_valid  <= '0;
            last_grant <= grant;
            state      <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed bench for fp_sqrt_arbiter with a behavioural fixed-latency fp_sqrt model.
module tb_fp_sqrt_arbiter;

  localparam int DATA_W  = 32;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_exc;
  logic [N_REQ-1:0]        rsp_ready = '0;
  logic                    sqrt_start;
  logic [DATA_W-1:0]       sqrt_op;
  logic                    sqrt_done = 1'b0;
  logic [DATA_W-1:0]       sqrt_res = '0;
  logic                    sqrt_exc = 1'b0;
  logic                    busy;
  logic                    timeout_err;

  fp_sqrt_arbiter #(
    .DATA_W  (DATA_W),
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_exc     (rsp_exc),
    .rsp_ready   (rsp_ready),
    .sqrt_start  (sqrt_start),
    .sqrt_op     (sqrt_op),
    .sqrt_done   (sqrt_done),
    .sqrt_res    (sqrt_res),
    .sqrt_exc    (sqrt_exc),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference square roots for the operands used here: {exc, result}.
  function automatic logic [32:0] sqrt_ref(input logic [31:0] op);
    case (op)
      32'h40800000: return {1'b0, 32'h40000000};
      32'h41100000: return {1'b0, 32'h40400000};
      32'h3F800000: return {1'b0, 32'h3F800000};
      32'h41800000: return {1'b0, 32'h40800000};
      32'hC0800000: return {1'b1, 32'h7FC00000};
      default:      return {1'b0, 32'h00000000};
    endcase
  endfunction

  // fp_sqrt model: done pulses model_lat cycles after the start cycle.
  int          model_lat = 31;
  bit          model_en = 1'b1;
  int          model_cnt = -1;
  logic [31:0] model_op = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      sqrt_done = 1'b0;
      if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0 && model_en) begin
          {sqrt_exc, sqrt_res} = sqrt_ref(model_op);
          sqrt_done = 1'b1;
        end
      end
      if (sqrt_start) begin
        model_cnt = model_lat;
        model_op  = sqrt_op;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic [31:0] op);
    req_valid[id] = 1'b1;
    req_data[id*DATA_W +: DATA_W] = op;
  endtask

  task automatic handshake(input int id);
    rsp_ready = '0;
    rsp_ready[id] = 1'b1;
    tick();
    rsp_ready = '0;
  endtask

  // Waits for rsp_valid; n counts cycles waited.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
    if (rsp_valid == '0) begin
      checks++;
      failures++;
      $display("FAIL wait_rsp: no rsp_valid after %0d cycles, required within 200", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ctrl", {req_ready, rsp_valid, rsp_exc, sqrt_start, busy, timeout_err}, 64'h0);
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_sqrt_op", sqrt_op, 64'h0);
    rst = 1'b0;
    #1;
  endtask

  typedef struct {
    int          id;
    logic [31:0] op;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[5];
  int   rr_exp[5];

  // Single request from an idle arbiter, checking timing and the result.
  task automatic run_vector(input vec_t v);
    int n;
    req_valid = '0;
    set_req(v.id, v.op);
    #1;
    check("ready_onehot", req_ready, 64'(1 << v.id));
    tick();
    req_valid = '0;
    #1;
    check("start_pulse_hi", sqrt_start, 64'h1);
    check("sqrt_op", sqrt_op, v.op);
    check("busy_ready_issue", {busy, req_ready}, 64'h10);
    tick();
    check("start_pulse_lo", sqrt_start, 64'h0);
    wait_rsp(n);
    check("rsp_latency", n + 2, 64'd33);
    check("rsp_valid_onehot", rsp_valid, 64'(1 << v.id));
    check("rsp_data", rsp_data, v.exp_res);
    check("rsp_exc", rsp_exc, v.exp_exc);
    handshake(v.id);
    check("idle_after_hs", {busy, rsp_valid}, 64'h0);
  endtask

  initial begin
    int          n;
    logic [31:0] held;

    vecs[0] = '{id: 1, op: 32'h40800000, exp_res: 32'h40000000, exp_exc: 1'b0};
    vecs[1] = '{id: 0, op: 32'h41100000, exp_res: 32'h40400000, exp_exc: 1'b0};
    vecs[2] = '{id: 3, op: 32'h3F800000, exp_res: 32'h3F800000, exp_exc: 1'b0};
    vecs[3] = '{id: 2, op: 32'hC0800000, exp_res: 32'h7FC00000, exp_exc: 1'b1};
    vecs[4] = '{id: 1, op: 32'h41800000, exp_res: 32'h40800000, exp_exc: 1'b0};
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset();

    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i]);
    end

    // Round-robin with all requesters held valid from reset.
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = 32'h40800000;
    end
    req_valid = '1;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      check("rr_grant", req_ready, 64'(1 << rr_exp[g]));
      tick();
      if (g == 4) begin
        req_valid = '0;
      end
      #1;
      check("rr_busy_no_ready", {busy, req_ready}, 64'h10);
      wait_rsp(n);
      check("rr_rsp_valid", rsp_valid, 64'(1 << rr_exp[g]));
      handshake(rr_exp[g]);
    end

    // Backpressure: result held while a new request waits; others' rsp_ready ignored.
    set_req(0, 32'h40800000);
    tick();
    req_valid = '0;
    wait_rsp(n);
    set_req(2, 32'h41100000);
    rsp_ready = 4'b1110;
    held = rsp_data;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_hold", {req_ready, rsp_valid, rsp_data}, {4'b0000, 4'b0001, 32'h40000000});
      tick();
    end
    check("bp_data_stable", rsp_data, held);
    handshake(0);
    check("bp_next_grant", req_ready, 64'h4);
    tick();
    req_valid = '0;
    wait_rsp(n);
    check("bp_rsp2", {rsp_valid, rsp_data}, {4'b0100, 32'h40400000});
    handshake(2);

    // Timeout: model never answers.
    do_reset();
    model_en = 1'b0;
    set_req(3, 32'h40800000);
    tick();
    req_valid = '0;
    tick();
    wait_rsp(n);
    check("to_latency", n + 2, 64'd66);
    check("to_rsp", {rsp_valid, rsp_exc, timeout_err, rsp_data}, {4'b1000, 1'b1, 1'b1, 32'h0});
    handshake(3);
    model_en = 1'b1;
    run_vector(vecs[1]);
    check("to_sticky", timeout_err, 64'h1);
    do_reset();
    check("to_cleared", timeout_err, 64'h0);

    // Done on the final timer cycle wins; timeout_err untouched.
    model_lat = 64;
    set_req(0, 32'h41100000);
    tick();
    req_valid = '0;
    tick();
    wait_rsp(n);
    check("tie_latency", n + 2, 64'd66);
    check("tie_rsp", {rsp_exc, timeout_err, rsp_data}, {1'b0, 1'b0, 32'h40400000});
    handshake(0);

    // Done one cycle too late lands in RESP and is ignored.
    model_lat = 65;
    set_req(1, 32'h41100000);
    tick();
    req_valid = '0;
    tick();
    wait_rsp(n);
    check("late_latency", n + 2, 64'd66);
    tick();
    check("late_rsp", {rsp_valid, rsp_exc, timeout_err, rsp_data}, {4'b0010, 1'b1, 1'b1, 32'h0});
    handshake(1);
    do_reset();

    // Reset mid-WAIT; the late done must be ignored and requester 0 wins next.
    model_lat = 31;
    run_vector(vecs[0]);
    set_req(2, 32'h40800000);
    tick();
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
    end
    check("mid_busy", busy, 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!sqrt_done && n < 60) begin
      tick();
      n++;
    end
    check("mid_done_cycle", {req_ready, rsp_valid, rsp_exc, sqrt_start, busy, timeout_err}, 64'h0);
    tick();
    check("mid_after_done", {req_ready, rsp_valid, rsp_exc, sqrt_start, busy, timeout_err}, 64'h0);
    check("mid_rsp_data", {rsp_data, sqrt_op}, 64'h0);
    req_valid = '1;
    #1;
    check("mid_next_grant", req_ready, 64'h1);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
